// File: rtl/bt_pen_pkg.sv
// Shared types for the Bluetooth pen receive path.
// Frame header, command codes, parser states and the move bundle.
package bt_pen_pkg;

    localparam logic [7:0] FRAME_HDR = 8'hA5;

    typedef enum logic [1:0] {
        CMD_PLACE   = 2'd1,
        CMD_UNDO    = 2'd2,
        CMD_RESTART = 2'd3
    } cmd_t;

    typedef enum logic [2:0] {
        HUNT,
        GET_X,
        GET_Y,
        GET_CMD,
        GET_SUM
    } pstate_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] cmd;
    } move_t;

    function automatic logic [7:0] frame_sum(
        input logic [7:0] x,
        input logic [7:0] y,
        input logic [7:0] c
    );
        return x + y + c;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/bt_uart_rx.sv
// 8N1 UART byte receiver with input synchroniser.
// Emits one-cycle byte_valid or ferr at the stop-bit centre.
module bt_uart_rx
    import bt_pen_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       ferr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    rx_state_t     state, nxt;
    logic [1:0]    sync_q;
    logic [1:0]    warm_q;
    logic          armed_q;
    logic          rx_prev;
    logic          rx_s;
    logic          fall;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_q;
    logic          half_hit;
    logic          full_hit;

    assign rx_s     = sync_q[1];
    assign fall     = armed_q & rx_prev & ~rx_s;
    assign half_hit = (cnt == HALF_M1);
    assign full_hit = (cnt == FULL_M1);
    assign byte_data = shift_q;

    // Synchronise the line; arm start detection only once a real high is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            warm_q  <= 2'b00;
            armed_q <= 1'b0;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], rx};
            warm_q  <= {warm_q[0], 1'b1};
            rx_prev <= rx_s;
            if (warm_q[1] && rx_s)
                armed_q <= 1'b1;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= RX_IDLE;
        else
            state <= nxt;
    end

    // Receiver next-state decode.
    always_comb begin
        nxt = state;
        case (state)
            RX_IDLE:  if (fall) nxt = RX_START;
            RX_START: if (half_hit) nxt = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_hit && bit_idx == 3'd7) nxt = RX_STOP;
            RX_STOP:  if (full_hit) nxt = RX_IDLE;
            default:  nxt = RX_IDLE;
        endcase
    end

    // Bit timing counter and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift_q <= '0;
        end else begin
            case (state)
                RX_START: cnt <= half_hit ? '0 : cnt + 1'b1;
                RX_DATA: begin
                    if (full_hit) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        shift_q <= {rx_s, shift_q[7:1]};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: cnt <= full_hit ? '0 : cnt + 1'b1;
                default: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                end
            endcase
        end
    end

    // Stop-bit verdict pulses.
    always_comb begin
        byte_valid = 1'b0;
        ferr       = 1'b0;
        if (state == RX_STOP && full_hit) begin
            byte_valid = rx_s;
            ferr       = ~rx_s;
        end
    end

endmodule

// File: rtl/bt_pen_frame_rx.sv
// Pen frame receiver: parses 5-byte move frames from the UART.
// Holds one validated move and keeps saturating error counters.
module bt_pen_frame_rx
    import bt_pen_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int BAUD         = 9600,
    parameter int TIMEOUT_BITS = 20,
    parameter int BOARD_N      = 15
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       uart_rx,
    output logic       move_valid,
    input  logic       move_ready,
    output logic [3:0] move_x,
    output logic [3:0] move_y,
    output logic [1:0] move_cmd,
    output logic [7:0] sum_err_cnt,
    output logic [7:0] frm_err_cnt,
    output logic       overrun,
    input  logic       clr_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int TMO_LIMIT    = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW           = $clog2(TMO_LIMIT + 2);

    logic [7:0] byte_data;
    logic       byte_valid;
    logic       ferr;

    pstate_t    state, nxt;
    logic [7:0] x_q, y_q, c_q;
    logic [TW-1:0] tmo_cnt;
    logic       tmo_hit;
    logic       sum_ok, cmd_ok, rng_ok, checks_ok;
    logic       frame_ok, sum_fail, frm_fail;
    logic       load, drop;
    move_t      hold_q;
    move_t      cand;

    bt_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (ACLK),
        .rst       (ARESET),
        .rx        (uart_rx),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .ferr      (ferr)
    );

    assign tmo_hit = (tmo_cnt == TW'(TMO_LIMIT));

    assign sum_ok = (byte_data == frame_sum(x_q, y_q, c_q));
    assign cmd_ok = (c_q[7:2] == 6'd0) && (c_q[1:0] != 2'd0);
    assign rng_ok = (c_q[1:0] != CMD_PLACE)
                 || ((x_q < 8'(BOARD_N)) && (y_q < 8'(BOARD_N)));
    assign checks_ok = sum_ok & cmd_ok & rng_ok;

    assign cand = '{x: x_q[3:0], y: y_q[3:0], cmd: c_q[1:0]};

    // Parser state register.
    always_ff @(posedge ACLK) begin
        if (ARESET)
            state <= HUNT;
        else
            state <= nxt;
    end

    // Parser next state; errors mid-frame fall back to HUNT.
    always_comb begin
        nxt = state;
        if (state != HUNT && (ferr || (tmo_hit && !byte_valid))) begin
            nxt = HUNT;
        end else if (byte_valid) begin
            case (state)
                HUNT:    if (byte_data == FRAME_HDR) nxt = GET_X;
                GET_X:   nxt = GET_Y;
                GET_Y:   nxt = GET_CMD;
                GET_CMD: nxt = GET_SUM;
                GET_SUM: nxt = HUNT;
                default: nxt = HUNT;
            endcase
        end
    end

    // Parser verdicts for the current cycle.
    always_comb begin
        frame_ok = 1'b0;
        sum_fail = 1'b0;
        frm_fail = 1'b0;
        if (state != HUNT) begin
            if (byte_valid) begin
                if (state == GET_SUM) begin
                    frame_ok = checks_ok;
                    sum_fail = ~checks_ok;
                end
            end else if (ferr || tmo_hit) begin
                frm_fail = 1'b1;
            end
        end
    end

    // Capture frame fields as they arrive.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            x_q <= '0;
            y_q <= '0;
            c_q <= '0;
        end else if (byte_valid) begin
            case (state)
                GET_X:   x_q <= byte_data;
                GET_Y:   y_q <= byte_data;
                GET_CMD: c_q <= byte_data;
                default: ;
            endcase
        end
    end

    // Inter-byte gap timer, cleared by each byte and while hunting.
    always_ff @(posedge ACLK) begin
        if (ARESET || state == HUNT || byte_valid)
            tmo_cnt <= '0;
        else if (!tmo_hit)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign load = frame_ok & (~move_valid | move_ready);
    assign drop = frame_ok & move_valid & ~move_ready;

    // One-entry move holding register with valid/ready handoff.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            move_valid <= 1'b0;
            hold_q     <= '0;
        end else if (load) begin
            move_valid <= 1'b1;
            hold_q     <= cand;
        end else if (move_valid && move_ready) begin
            move_valid <= 1'b0;
        end
    end

    assign move_x   = hold_q.x;
    assign move_y   = hold_q.y;
    assign move_cmd = hold_q.cmd;

    // Saturating error counters and sticky overrun; clear wins.
    always_ff @(posedge ACLK) begin
        if (ARESET || clr_err) begin
            sum_err_cnt <= '0;
            frm_err_cnt <= '0;
            overrun     <= 1'b0;
        end else begin
            if (sum_fail)
                sum_err_cnt <= sat_inc(sum_err_cnt);
            if (frm_fail)
                frm_err_cnt <= sat_inc(frm_err_cnt);
            if (drop)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bt_pen_frame_rx.sv
// Self-checking bench for bt_pen_frame_rx at 10 clocks per bit.
// Directed scenarios plus random frames against a frame-rule model.
module tb_bt_pen_frame_rx;

    logic       ACLK = 1'b0;
    logic       ARESET;
    logic       uart_rx;
    logic       move_valid;
    logic       move_ready;
    logic [3:0] move_x;
    logic [3:0] move_y;
    logic [1:0] move_cmd;
    logic [7:0] sum_err_cnt;
    logic [7:0] frm_err_cnt;
    logic       overrun;
    logic       clr_err;

    int errors = 0;
    int checks = 0;
    logic mv_at [10];

    always #5 ACLK = ~ACLK;

    bt_pen_frame_rx #(
        .CLK_FREQ_HZ (1_000_000),
        .BAUD        (100_000),
        .TIMEOUT_BITS(20),
        .BOARD_N     (15)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .uart_rx    (uart_rx),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .move_x     (move_x),
        .move_y     (move_y),
        .move_cmd   (move_cmd),
        .sum_err_cnt(sum_err_cnt),
        .frm_err_cnt(frm_err_cnt),
        .overrun    (overrun),
        .clr_err    (clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line changes on the falling clock edge; 10 clocks per bit.
    // mv_at[c] holds move_valid (c+1) cycles into the stop bit.
    task automatic send_byte(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            uart_rx = bits[b];
            for (int c = 0; c < 10; c++) begin
                @(negedge ACLK);
                if (b == 9) mv_at[c] = move_valid;
            end
        end
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge ACLK);
    endtask

    task automatic send_frame(input logic [7:0] x, input logic [7:0] y,
                              input logic [7:0] c, input logic [7:0] s);
        send_byte(8'hA5, 1'b1);
        send_byte(x, 1'b1);
        send_byte(y, 1'b1);
        send_byte(c, 1'b1);
        send_byte(s, 1'b1);
    endtask

    task automatic pulse_ready();
        move_ready = 1'b1;
        @(negedge ACLK);
        move_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge ACLK);
        clr_err = 1'b0;
    endtask

    function automatic bit model_ok(input int x, input int y,
                                    input int c, input int s);
        if (((x + y + c) % 256) != s) return 1'b0;
        if (c < 1 || c > 3) return 1'b0;
        if (c == 1 && (x >= 15 || y >= 15)) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        int x, y, c, s, exp_sum;
        bit ok;

        ARESET     = 1'b1;
        uart_rx    = 1'b1;
        move_ready = 1'b0;
        clr_err    = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("rst_valid", move_valid, 0);
        chk("rst_x", move_x, 0);
        chk("rst_cmd", move_cmd, 0);
        chk("rst_sum", sum_err_cnt, 0);
        chk("rst_frm", frm_err_cnt, 0);
        chk("rst_ovr", overrun, 0);
        ARESET = 1'b0;
        idle(20);

        // Good place frame and its output latency.
        send_frame(8'h03, 8'h07, 8'h01, 8'h0B);
        chk("lat_before", mv_at[6], 0);
        chk("lat_rise", mv_at[7], 1);
        chk("a_x", move_x, 3);
        chk("a_y", move_y, 7);
        chk("a_cmd", move_cmd, 1);
        chk("a_sum", sum_err_cnt, 0);
        chk("a_frm", frm_err_cnt, 0);
        pulse_ready();
        chk("a_drop", move_valid, 0);

        // Checksum failure, then range failure.
        idle(10);
        send_frame(8'h03, 8'h07, 8'h01, 8'h0C);
        idle(5);
        chk("bad_sum_valid", move_valid, 0);
        chk("bad_sum_cnt", sum_err_cnt, 1);
        send_frame(8'h0F, 8'h00, 8'h01, 8'h10);
        idle(5);
        chk("range_valid", move_valid, 0);
        chk("range_cnt", sum_err_cnt, 2);

        // Junk before header, then an undo.
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_frame(8'h00, 8'h00, 8'h02, 8'h02);
        chk("junk_valid", move_valid, 1);
        chk("junk_cmd", move_cmd, 2);
        chk("junk_sum", sum_err_cnt, 2);
        pulse_ready();

        // Framing error on X, then a good frame.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b0);
        idle(20);
        chk("ferr_cnt", frm_err_cnt, 1);
        send_frame(8'h05, 8'h06, 8'h01, 8'h0C);
        chk("ferr_next_valid", move_valid, 1);
        chk("ferr_next_x", move_x, 5);
        chk("ferr_next_y", move_y, 6);
        pulse_ready();

        pulse_clr();
        chk("clr_sum", sum_err_cnt, 0);
        chk("clr_frm", frm_err_cnt, 0);

        // Inter-byte timeout.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h01, 1'b1);
        idle(250);
        send_byte(8'h01, 1'b1);
        send_byte(8'h03, 1'b1);
        idle(10);
        chk("tmo_frm", frm_err_cnt, 1);
        chk("tmo_valid", move_valid, 0);
        chk("tmo_sum", sum_err_cnt, 0);

        // Overrun with the holding register full.
        send_frame(8'h02, 8'h04, 8'h01, 8'h07);
        send_frame(8'h09, 8'h09, 8'h03, 8'h15);
        chk("ovr_valid", move_valid, 1);
        chk("ovr_x", move_x, 2);
        chk("ovr_y", move_y, 4);
        chk("ovr_cmd", move_cmd, 1);
        chk("ovr_flag", overrun, 1);
        pulse_ready();
        chk("ovr_drop", move_valid, 0);
        pulse_clr();
        chk("ovr_clr", overrun, 0);

        // Short low glitch must not start a byte.
        uart_rx = 1'b0;
        repeat (3) @(negedge ACLK);
        idle(20);
        send_frame(8'h0A, 8'h0B, 8'h03, 8'h18);
        chk("glitch_valid", move_valid, 1);
        chk("glitch_x", move_x, 4'hA);
        chk("glitch_frm", frm_err_cnt, 0);
        pulse_ready();

        // Random frames against the frame-rule model.
        exp_sum = 0;
        for (int i = 0; i < 20; i++) begin
            x = $urandom_range(0, 16);
            y = $urandom_range(0, 16);
            c = $urandom_range(0, 3);
            s = (x + y + c) % 256;
            if ($urandom_range(0, 3) == 0)
                s = (s + 1 + $urandom_range(0, 5)) % 256;
            ok = model_ok(x, y, c, s);
            send_frame(8'(x), 8'(y), 8'(c), 8'(s));
            idle(5);
            chk("rnd_valid", move_valid, 32'(ok));
            if (ok) begin
                chk("rnd_x", move_x, x % 16);
                chk("rnd_y", move_y, y % 16);
                chk("rnd_cmd", move_cmd, c);
                pulse_ready();
            end else begin
                exp_sum++;
            end
        end
        chk("rnd_sum", sum_err_cnt, exp_sum);
        pulse_clr();

        // Framing counter saturation.
        for (int i = 0; i < 258; i++) begin
            send_byte(8'hA5, 1'b1);
            send_byte(8'h55, 1'b0);
            idle(5);
            if (i == 253) chk("sat_pre", frm_err_cnt, 8'hFE);
        end
        chk("sat_frm", frm_err_cnt, 8'hFF);
        chk("sat_sum", sum_err_cnt, 0);

        // Reset in the middle of the Y byte.
        send_frame(8'h01, 8'h02, 8'h01, 8'h05);
        send_frame(8'h01, 8'h02, 8'h01, 8'h04);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        uart_rx = 1'b0;
        repeat (35) @(negedge ACLK);
        ARESET = 1'b1;
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("mid_rst_valid", move_valid, 0);
        chk("mid_rst_x", move_x, 0);
        chk("mid_rst_sum", sum_err_cnt, 0);
        chk("mid_rst_frm", frm_err_cnt, 0);
        repeat (10) @(negedge ACLK);
        idle(30);
        send_frame(8'h0E, 8'h0E, 8'h01, 8'h1D);
        chk("post_rst_valid", move_valid, 1);
        chk("post_rst_x", move_x, 4'hE);
        chk("post_rst_y", move_y, 4'hE);
        chk("post_rst_sum", sum_err_cnt, 0);
        chk("post_rst_frm", frm_err_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
